// File: rtl/multi_wave_gen.sv
// Multi-channel DDS: per-channel phase accumulators share one pipelined CORDIC that
// produces sine, cosine and a mode-selected waveform (sine, cosine, triangle, square).
module multi_wave_gen #(
  parameter int unsigned OUT_W   = 12,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned NCH     = 4,
  localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_we,
  input  logic [CW-1:0]           cfg_ch,
  input  logic [PHASE_W-1:0]      cfg_ftw,
  input  logic [PHASE_W-1:0]      cfg_off,
  input  logic [1:0]              cfg_mode,
  input  logic                    cfg_sync,
  output logic                    out_valid,
  output logic [CW-1:0]           out_ch,
  output logic signed [OUT_W-1:0] out_sin,
  output logic signed [OUT_W-1:0] out_cos,
  output logic signed [OUT_W-1:0] out_wave
);

  localparam int unsigned G  = 2;  // guard bits in the CORDIC datapath
  localparam int unsigned XW = OUT_W + G + 2;
  localparam int unsigned ZW = PHASE_W;

  localparam int                      AMP    = (2 ** (OUT_W - 1)) - 1;
  localparam logic signed [OUT_W-1:0] AMP_O  = OUT_W'(AMP);
  localparam logic signed [OUT_W-1:0] MIN_O  = {1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic signed [XW-1:0]    AMP_X  = XW'(AMP);
  localparam logic signed [XW-1:0]    RND    = XW'(2 ** (G - 1));
  // Start vector pre-divided by the CORDIC gain (1/K = 0.60725 as Q0.32).
  localparam logic [63:0]             KINV   = 64'h9B74_EDA9;
  localparam logic [63:0]             X0_W   = ((64'(AMP) << G) * KINV + 64'h8000_0000) >> 32;
  localparam logic signed [XW-1:0]    X0     = XW'(X0_W);

  // atan(2^-i) as a fraction of a full turn, scaled from a 32-bit turn to ZW bits.
  function automatic logic [ZW-1:0] atan_ang(input int i);
    logic [32:0] t;
    int          sh;
    case (i)
      0:  t = 33'h2000_0000;  1:  t = 33'h12E4_051E;  2:  t = 33'h09FB_385B;
      3:  t = 33'h0511_11D4;  4:  t = 33'h028B_0D43;  5:  t = 33'h0145_D7E1;
      6:  t = 33'h00A2_F61E;  7:  t = 33'h0051_7C55;  8:  t = 33'h0028_BE53;
      9:  t = 33'h0014_5F2F;  10: t = 33'h000A_2F98;  11: t = 33'h0005_17CC;
      12: t = 33'h0002_8BE6;  13: t = 33'h0001_45F3;  14: t = 33'h0000_A2FA;
      15: t = 33'h0000_517D;  16: t = 33'h0000_28BE;  17: t = 33'h0000_145F;
      18: t = 33'h0000_0A30;  19: t = 33'h0000_0518;  20: t = 33'h0000_028C;
      21: t = 33'h0000_0146;  22: t = 33'h0000_00A3;  23: t = 33'h0000_0051;
      24: t = 33'h0000_0029;  25: t = 33'h0000_0014;  26: t = 33'h0000_000A;
      27: t = 33'h0000_0005;  28: t = 33'h0000_0003;  29: t = 33'h0000_0001;
      default: t = 33'h0;
    endcase
    sh = 32 - int'(ZW);
    if (sh <= 0) return ZW'(t);
    return ZW'((t + (33'd1 << (sh - 1))) >> sh);
  endfunction

  function automatic logic signed [OUT_W-1:0] scale(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] r;
    r = (v + RND) >>> G;
    if (r > AMP_X) return AMP_O;
    if (r < -AMP_X) return -AMP_O;
    return OUT_W'(r);
  endfunction

  // Channel state and issue stage
  logic [CW-1:0]      ptr;
  logic [PHASE_W-1:0] acc    [NCH];
  logic [PHASE_W-1:0] ftw    [NCH];
  logic [PHASE_W-1:0] off    [NCH];
  logic [1:0]         mode_r [NCH];

  logic               iss_valid;
  logic [CW-1:0]      iss_ch;
  logic [PHASE_W-1:0] iss_p;
  logic [1:0]         iss_mode;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      iss_valid <= 1'b0;
      iss_ch    <= '0;
      iss_p     <= '0;
      iss_mode  <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        acc[i]    <= '0;
        ftw[i]    <= '0;
        off[i]    <= '0;
        mode_r[i] <= '0;
      end
    end else begin
      iss_valid <= enable;
      if (enable) begin
        iss_ch   <= ptr;
        iss_p    <= acc[ptr] + off[ptr];
        iss_mode <= mode_r[ptr];
        acc[ptr] <= acc[ptr] + ftw[ptr];
        ptr      <= (ptr == CW'(NCH - 1)) ? '0 : ptr + 1'b1;
      end
      // Placed after the issue update so a same-cycle write wins the accumulator.
      if (cfg_we) begin
        ftw[cfg_ch]    <= cfg_ftw;
        off[cfg_ch]    <= cfg_off;
        mode_r[cfg_ch] <= cfg_mode;
        if (cfg_sync) acc[cfg_ch] <= '0;
      end
    end
  end

  // Triangle and square from the issued phase; they ride the pipeline as aux.
  logic [OUT_W:0]          u;
  logic signed [OUT_W-1:0] tri_v;
  logic signed [OUT_W-1:0] sq_v;

  always_comb begin
    u = iss_p[PHASE_W-1 -: OUT_W + 1];
    // L - 2^(N-1) is L with its MSB flipped; 2^(N-1)-1-L is ~L with its MSB flipped.
    tri_v = u[OUT_W] ? {u[OUT_W-1], ~u[OUT_W-2:0]} : {~u[OUT_W-1], u[OUT_W-2:0]};
    if (tri_v == MIN_O) tri_v = -AMP_O;
    sq_v = iss_p[PHASE_W-1] ? -AMP_O : AMP_O;
  end

  // Fold stage (index 0) followed by OUT_W rotation stages (indices 1..OUT_W).
  logic                    vld  [OUT_W+1];
  logic [CW-1:0]           chs  [OUT_W+1];
  logic [1:0]              mds  [OUT_W+1];
  logic [1:0]              qs   [OUT_W+1];
  logic signed [OUT_W-1:0] auxs [OUT_W+1];
  logic signed [XW-1:0]    xs   [OUT_W+1];
  logic signed [XW-1:0]    ys   [OUT_W+1];
  logic signed [ZW-1:0]    zs   [OUT_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= int'(OUT_W); i++) begin
        vld[i]  <= 1'b0;
        chs[i]  <= '0;
        mds[i]  <= '0;
        qs[i]   <= '0;
        auxs[i] <= '0;
        xs[i]   <= '0;
        ys[i]   <= '0;
      end
      for (int i = 0; i < int'(OUT_W); i++) zs[i] <= '0;
    end else begin
      vld[0]  <= iss_valid;
      chs[0]  <= iss_ch;
      mds[0]  <= iss_mode;
      qs[0]   <= iss_p[PHASE_W-1 -: 2];
      auxs[0] <= iss_mode[0] ? sq_v : tri_v;
      xs[0]   <= X0;
      ys[0]   <= '0;
      zs[0]   <= {2'b00, iss_p[PHASE_W-3:0]};
      for (int i = 0; i < int'(OUT_W); i++) begin
        vld[i+1]  <= vld[i];
        chs[i+1]  <= chs[i];
        mds[i+1]  <= mds[i];
        qs[i+1]   <= qs[i];
        auxs[i+1] <= auxs[i];
        if (zs[i][ZW-1]) begin
          xs[i+1] <= xs[i] + (ys[i] >>> i);
          ys[i+1] <= ys[i] - (xs[i] >>> i);
        end else begin
          xs[i+1] <= xs[i] - (ys[i] >>> i);
          ys[i+1] <= ys[i] + (xs[i] >>> i);
        end
      end
      for (int i = 0; i < int'(OUT_W) - 1; i++) begin
        zs[i+1] <= zs[i][ZW-1] ? zs[i] + atan_ang(i) : zs[i] - atan_ang(i);
      end
    end
  end

  // Post stage: round, saturate, undo the quadrant fold.
  logic signed [OUT_W-1:0] sy, cx, sin_d, cos_d;

  always_comb begin
    sy    = scale(ys[OUT_W]);
    cx    = scale(xs[OUT_W]);
    sin_d = sy;
    cos_d = cx;
    unique case (qs[OUT_W])
      2'd0: begin sin_d = sy;  cos_d = cx;  end
      2'd1: begin sin_d = cx;  cos_d = -sy; end
      2'd2: begin sin_d = -sy; cos_d = -cx; end
      2'd3: begin sin_d = -cx; cos_d = sy;  end
      default: ;
    endcase
  end

  logic                    post_valid;
  logic [CW-1:0]           post_ch;
  logic [1:0]              post_mode;
  logic signed [OUT_W-1:0] post_sin, post_cos, post_aux;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      post_valid <= 1'b0;
      post_ch    <= '0;
      post_mode  <= '0;
      post_sin   <= '0;
      post_cos   <= '0;
      post_aux   <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sin    <= '0;
      out_cos    <= '0;
      out_wave   <= '0;
    end else begin
      post_valid <= vld[OUT_W];
      post_ch    <= chs[OUT_W];
      post_mode  <= mds[OUT_W];
      post_sin   <= sin_d;
      post_cos   <= cos_d;
      post_aux   <= auxs[OUT_W];
      out_valid  <= post_valid;
      if (post_valid) begin
        out_ch  <= post_ch;
        out_sin <= post_sin;
        out_cos <= post_cos;
        unique case (post_mode)
          2'd0:    out_wave <= post_sin;
          2'd1:    out_wave <= post_cos;
          default: out_wave <= post_aux;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_wave_gen.sv
// Directed self-checking bench for multi_wave_gen: latency, sine/cosine, square,
// triangle, same-cycle sync write, enable bubbles and mid-stream reset.
module tb_multi_wave_gen;

  localparam int OUT_W   = 12;
  localparam int PHASE_W = 16;
  localparam int NCH     = 4;
  localparam int CW      = 2;
  localparam int A       = 2047;
  localparam int LAT     = OUT_W + 3;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    enable = 1'b0;
  logic                    cfg_we = 1'b0;
  logic [CW-1:0]           cfg_ch = '0;
  logic [PHASE_W-1:0]      cfg_ftw = '0;
  logic [PHASE_W-1:0]      cfg_off = '0;
  logic [1:0]              cfg_mode = '0;
  logic                    cfg_sync = 1'b0;
  logic                    out_valid;
  logic [CW-1:0]           out_ch;
  logic signed [OUT_W-1:0] out_sin, out_cos, out_wave;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  multi_wave_gen #(.OUT_W(OUT_W), .PHASE_W(PHASE_W), .NCH(NCH)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_ftw  (cfg_ftw),
    .cfg_off  (cfg_off),
    .cfg_mode (cfg_mode),
    .cfg_sync (cfg_sync),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out_sin  (out_sin),
    .out_cos  (out_cos),
    .out_wave (out_wave)
  );

  // Leaves the bench at a falling edge with reset released and enable low.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_sync = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input logic [PHASE_W-1:0] ftw,
                           input logic [PHASE_W-1:0] off, input int mode, input bit sync);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_ftw = ftw; cfg_off = off;
    cfg_mode = 2'(mode); cfg_sync = sync;
    @(negedge clock);
    cfg_we = 1'b0; cfg_sync = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    vectors++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %0d want 0", out_valid); end
    vectors++; if (out_ch !== '0) begin errors++;
      $display("FAIL reset_ch: got %0d want 0", out_ch); end
    vectors++; if (out_sin !== '0) begin errors++;
      $display("FAIL reset_sin: got %0d want 0", out_sin); end
    vectors++; if (out_cos !== '0) begin errors++;
      $display("FAIL reset_cos: got %0d want 0", out_cos); end
    vectors++; if (out_wave !== '0) begin errors++;
      $display("FAIL reset_wave: got %0d want 0", out_wave); end
  endtask

  task automatic test_sine();
    int cyc, s, c, w, ech;
    do_reset();
    cfg_write(0, 16'h0000, 16'h4000, 0, 1'b1);
    enable = 1'b1;
    cyc = -1;
    for (int e = 0; e < 40 && cyc < 0; e++) begin
      @(negedge clock);
      if (out_valid === 1'b1) cyc = e;
    end
    vectors++; if (cyc != LAT) begin errors++;
      $display("FAIL first_valid_cycle: got %0d want %0d", cyc, LAT); end
    for (int k = 0; k < 12; k++) begin
      ech = k % NCH;
      s = out_sin; c = out_cos; w = out_wave;
      vectors++; if (out_valid !== 1'b1 || out_ch !== CW'(ech)) begin errors++;
        $display("FAIL sine_seq[%0d]: got v=%0d ch=%0d want v=1 ch=%0d", k, out_valid, out_ch, ech);
      end
      if (ech == 0) begin
        vectors++; if (s < A - 3 || s > A || c < -3 || c > 3 || w != s) begin errors++;
          $display("FAIL sine_ch0[%0d]: got sin=%0d cos=%0d wave=%0d want sin=2047+-3 cos=0+-3 wave=sin",
                   k, s, c, w);
        end
      end else begin
        vectors++; if (s < -3 || s > 3 || c < A - 3 || c > A) begin errors++;
          $display("FAIL sine_chx[%0d]: got sin=%0d cos=%0d want sin=0+-3 cos=2047+-3", k, s, c);
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_square();
    int k;
    logic signed [OUT_W-1:0] exp_w;
    do_reset();
    cfg_write(1, 16'h0400, 16'h0000, 3, 1'b1);
    enable = 1'b1;
    k = 0;
    for (int e = 0; e < 400 && k < 70; e++) begin
      @(negedge clock);
      if (out_valid === 1'b1 && out_ch === 2'd1) begin
        exp_w = ((k % 64) < 32) ? 12'sd2047 : -12'sd2047;
        vectors++; if (out_wave !== exp_w) begin errors++;
          $display("FAIL square[%0d]: got %0d want %0d", k, out_wave, exp_w); end
        k++;
      end
    end
    vectors++; if (k != 70) begin errors++;
      $display("FAIL square_count: got %0d want 70", k); end
  endtask

  task automatic test_triangle();
    int k, kk, exp_i, w;
    do_reset();
    cfg_write(2, 16'h0100, 16'h0000, 2, 1'b1);
    enable = 1'b1;
    k = 0;
    for (int e = 0; e < 1200 && k < 260; e++) begin
      @(negedge clock);
      if (out_valid === 1'b1 && out_ch === 2'd2) begin
        kk = k % 256;
        if (kk == 0)       exp_i = -A;
        else if (kk < 128) exp_i = -2048 + 32 * kk;
        else               exp_i = 2047 - 32 * (kk - 128);
        w = out_wave;
        vectors++; if (w != exp_i) begin errors++;
          $display("FAIL triangle[%0d]: got %0d want %0d", k, w, exp_i); end
        k++;
      end
    end
    vectors++; if (k != 260) begin errors++;
      $display("FAIL triangle_count: got %0d want 260", k); end
  endtask

  task automatic test_sync();
    int exp_sin [5] = '{0, 783, 1447, 0, -50};
    int exp_wave[5] = '{0, 783, 1447, -2047, -2047};
    int wave_tol[5] = '{3, 3, 3, 0, 0};
    int k, s, w;
    do_reset();
    cfg_write(3, 16'h1000, 16'h0000, 0, 1'b1);
    enable = 1'b1;
    k = 0;
    for (int e = 0; e < 80 && k < 5; e++) begin
      // Cycle 11 is ch3's third issue; write new settings with sync in that same cycle.
      if (e == 11) begin
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_ftw = 16'h0100; cfg_off = 16'h8000;
        cfg_mode = 2'd3; cfg_sync = 1'b1;
      end
      @(negedge clock);
      cfg_we = 1'b0; cfg_sync = 1'b0;
      if (out_valid === 1'b1 && out_ch === 2'd3) begin
        s = out_sin; w = out_wave;
        vectors++;
        if (s < exp_sin[k] - 3 || s > exp_sin[k] + 3 ||
            w < exp_wave[k] - wave_tol[k] || w > exp_wave[k] + wave_tol[k]) begin
          errors++;
          $display("FAIL sync[%0d]: got sin=%0d wave=%0d want sin=%0d+-3 wave=%0d+-%0d",
                   k, s, w, exp_sin[k], exp_wave[k], wave_tol[k]);
        end
        k++;
      end
    end
    vectors++; if (k != 5) begin errors++;
      $display("FAIL sync_count: got %0d want 5", k); end
  endtask

  task automatic test_back_to_back();
    bit pat    [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int exp_ch [6] = '{0, 0, 0, 1, 2, 3};
    bit ev;
    int c;
    do_reset();
    for (int e = 0; e < 26; e++) begin
      enable = (e < 6) ? pat[e] : 1'b0;
      @(negedge clock);
      ev = (e >= LAT && e - LAT < 6) ? pat[e - LAT] : 1'b0;
      vectors++; if (out_valid !== ev) begin errors++;
        $display("FAIL bubble_valid[%0d]: got %0d want %0d", e, out_valid, ev); end
      if (ev) begin
        vectors++; if (out_ch !== CW'(exp_ch[e - LAT])) begin errors++;
          $display("FAIL bubble_ch[%0d]: got %0d want %0d", e, out_ch, exp_ch[e - LAT]); end
      end
      if (e >= LAT) begin
        c = out_cos;
        vectors++; if (c < A - 3 || c > A) begin errors++;
          $display("FAIL bubble_hold[%0d]: got cos=%0d want 2047+-3", e, c); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ev;
    int c;
    do_reset();
    enable = 1'b1;
    repeat (20) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_ch !== '0 || out_sin !== '0 ||
                   out_cos !== '0 || out_wave !== '0) begin
      errors++;
      $display("FAIL midreset_async: got v=%0d ch=%0d sin=%0d cos=%0d wave=%0d want all 0",
               out_valid, out_ch, out_sin, out_cos, out_wave);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int e = 0; e <= LAT; e++) begin
      @(negedge clock);
      ev = (e == LAT);
      vectors++; if (out_valid !== ev) begin errors++;
        $display("FAIL midreset_valid[%0d]: got %0d want %0d", e, out_valid, ev); end
      if (ev) begin
        c = out_cos;
        vectors++; if (out_ch !== '0 || c < A - 3 || c > A) begin errors++;
          $display("FAIL midreset_restart: got ch=%0d cos=%0d want ch=0 cos=2047+-3", out_ch, c);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sine();
    test_square();
    test_triangle();
    test_sync();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multi_wave_gen.md
MULTI_WAVE_GEN -- requirements
Module: multi_wave_gen

Interface
REQ-001 SHALL have parameter OUT_W, default 12, meaning signed output sample width.
REQ-002 SHALL have parameter PHASE_W, default 16, meaning phase accumulator and tuning word width (PHASE_W >= OUT_W+2).
REQ-003 SHALL have parameter NCH, default 4, meaning number of channels (power of two, 1..16).
REQ-004 SHALL have ports, in this order:
- clock, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous, active-high.
- enable, input, 1, permits channel issue.
- cfg_we, input, 1, configuration write strobe.
- cfg_ch, input, log2(NCH), target channel.
- cfg_ftw, input, PHASE_W, frequency tuning word.
- cfg_off, input, PHASE_W, phase offset.
- cfg_mode, input, 2, 0=sine, 1=cosine, 2=triangle, 3=square.
- cfg_sync, input, 1, clear the target accumulator on write.
- out_valid, output, 1, sample strobe.
- out_ch, output, log2(NCH), channel of the sample.
- out_sin, output, OUT_W signed.
- out_cos, output, OUT_W signed.
- out_wave, output, OUT_W signed, mode-selected waveform.

Function
REQ-005 SHALL hold a per-channel FTW, offset, mode and PHASE_W accumulator, with only one clock and the single reset.
REQ-006 SHALL step a round-robin channel pointer 0..NCH-1, wrapping to 0, on every cycle enable=1, and SHALL hold it when enable=0.
REQ-007 SHALL, in an issue cycle (enable=1, pointer=c), issue phase p = acc[c] + off[c] (mod 2^PHASE_W) and set acc[c] <= acc[c] + ftw[c] (mod 2^PHASE_W, wrap silent).
REQ-008 SHALL use a pipelined CORDIC of OUT_W rotation stages with a quadrant fold of p[PHASE_W-1:PHASE_W-2], accepting one issue per clock.
REQ-009 SHALL assert out_valid exactly OUT_W+3 cycles after an issue, with out_ch equal to the issued channel, and SHALL keep out_valid low for non-issue cycles, so enable gaps propagate as bubbles.
REQ-010 SHALL drive out_sin and out_cos as round(A*sin/cos(2*pi*p/2^PHASE_W)), A = 2^(OUT_W-1)-1, error <= 3 LSB, saturated to +/-A.
REQ-011 SHALL compute the triangle from u, the top OUT_W+1 bits of p, with L = the low OUT_W bits of u: L-2^(OUT_W-1) when u MSB=0, else 2^(OUT_W-1)-1-L, clamped to >= -A.
REQ-012 SHALL compute the square as +A when p MSB=0, else -A.
REQ-013 SHALL delay-match the triangle and square values to the CORDIC latency.
REQ-014 SHALL select out_wave by the mode registered at issue time.
REQ-015 SHALL apply a cfg_we write at the clock edge to ftw, off and mode of cfg_ch.
REQ-016 SHALL, when cfg_sync=1, also set acc[cfg_ch] <= 0.
REQ-017 SHALL, on a write to the channel issued in the same cycle, issue with the old values while the write wins acc (sync to 0, else acc updated with the old ftw), so new values take effect from that channel's next issue.
REQ-018 SHALL leave out_sin/out_cos/out_wave holding their last values while out_valid=0.

Reset
REQ-019 SHALL, on reset assertion (any time, asynchronously), clear every accumulator, ftw, off and mode to 0, the channel pointer to 0, and all pipeline valid bits.
REQ-020 SHALL drive out_valid, out_ch, out_sin, out_cos and out_wave to 0 during reset.
REQ-021 SHALL, after reset deassertion with enable=1, issue its first channel-0 sample on the first clock edge and output it OUT_W+3 cycles later.
REQ-022 SHALL discard in-flight samples on a reset during operation, with no valid output until fresh issues emerge.

Verification
REQ-023 SHALL cover: defaults, ch0 ftw=0 off=0x4000 mode=0, enable=1 -> every 4th cycle out_ch=0, out_sin=2047+/-3, out_cos=0+/-3, first valid at cycle 15.
REQ-024 SHALL cover: ch1 ftw=0x0400 mode=3 -> out_wave +2047 for 32 consecutive ch1 samples, then -2047 for 32, period 64 samples, acc wraps without glitch.
REQ-025 SHALL cover: ch2 ftw=0x0100 mode=2 -> out_wave steps +32 per sample from -2047 to 2047, then down, peak at phase 0x8000.
REQ-026 SHALL cover: cfg_we with cfg_sync=1 to ch3 in its issue cycle -> that sample uses old values; next ch3 sample phase = new off; acc restarted at 0.
REQ-027 SHALL cover: enable toggled 1,0,0,1 -> out_valid pattern 1,0,0,1 exactly OUT_W+3 later, channel order uninterrupted.
REQ-028 SHALL cover: reset pulse mid-stream -> outputs 0 immediately (asynchronously), no stale valid afterwards, sequence restarts at ch0.
